// File: rtl/mem_fill_ctrl.sv
// Cache line fill controller: optional dirty-line writeback, then a line read,
// with per-wait timeout and a sticky error state that only reset clears.
module mem_fill_ctrl #(
   parameter int unsigned ENTRIES = 256,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_fill,
   input  logic         req_wb,
   input  logic [26:0]  req_fill_addr,
   input  logic [26:0]  req_wb_addr,
   input  logic [255:0] req_wb_data,
   output logic         resp_valid,
   output logic [255:0] resp_data,
   output logic         wb_done,
   output logic         err,
   output logic [26:0]  mem_a,
   output logic [31:0]  mem_be,
   output logic [255:0] mem_wd,
   output logic         mem_write,
   output logic         mem_read,
   input  logic [255:0] mem_rd,
   input  logic         mem_valid,
   input  logic         mem_ready
);

   localparam int unsigned     CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [27:0]     ENTRIES_L = 28'(ENTRIES);

   typedef enum logic [2:0] {
      IDLE,
      WB_ISSUE,
      WB_WAIT,
      RD_ISSUE,
      RD_WAIT,
      RESP,
      ERROR
   } state_t;

   state_t             state_q, state_d;
   logic [26:0]        wb_addr_q, wb_addr_d;
   logic [26:0]        fill_addr_q, fill_addr_d;
   logic [255:0]       wb_data_q, wb_data_d;
   logic [255:0]       resp_data_q, resp_data_d;
   logic               fill_q, fill_d;
   logic               wb_done_q, wb_done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wb_oob, fill_oob;

   always_comb begin
      wb_oob   = req_wb   && ({1'b0, req_wb_addr}   >= ENTRIES_L);
      fill_oob = req_fill && ({1'b0, req_fill_addr} >= ENTRIES_L);
   end

   always_comb begin
      state_d     = state_q;
      wb_addr_d   = wb_addr_q;
      fill_addr_d = fill_addr_q;
      wb_data_d   = wb_data_q;
      fill_d      = fill_q;
      resp_data_d = resp_data_q;
      cnt_d       = cnt_q;
      wb_done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wb_addr_d   = req_wb_addr;
               fill_addr_d = req_fill_addr;
               wb_data_d   = req_wb_data;
               fill_d      = req_fill;
               if (wb_oob || fill_oob) begin
                  state_d = ERROR;
               end else if (req_wb) begin
                  state_d = WB_ISSUE;
               end else if (req_fill) begin
                  state_d = RD_ISSUE;
               end
            end
         end
         WB_ISSUE: begin
            state_d = WB_WAIT;
            cnt_d   = '0;
         end
         // The strobe wins over an expiring counter on the last allowed wait cycle.
         WB_WAIT: begin
            if (mem_ready) begin
               wb_done_d = 1'b1;
               state_d   = fill_q ? RD_ISSUE : IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
            cnt_d   = '0;
         end
         RD_WAIT: begin
            if (mem_valid) begin
               resp_data_d = mem_rd;
               state_d     = RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      err        = (state_q == ERROR);
      wb_done    = wb_done_q;
      resp_data  = resp_data_q;
      mem_a      = '0;
      mem_be     = '0;
      mem_wd     = '0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      case (state_q)
         WB_ISSUE: begin
            mem_write = 1'b1;
            mem_a     = wb_addr_q;
            mem_wd    = wb_data_q;
            mem_be    = '1;
         end
         RD_ISSUE: begin
            mem_read = 1'b1;
            mem_a    = fill_addr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_addr_q   <= '0;
         fill_addr_q <= '0;
         wb_data_q   <= '0;
         fill_q      <= 1'b0;
         resp_data_q <= '0;
         cnt_q       <= '0;
         wb_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wb_addr_q   <= wb_addr_d;
         fill_addr_q <= fill_addr_d;
         wb_data_q   <= wb_data_d;
         fill_q      <= fill_d;
         resp_data_q <= resp_data_d;
         cnt_q       <= cnt_d;
         wb_done_q   <= wb_done_d;
      end
   end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Bench for mem_fill_ctrl: a latency-programmable line memory, a table of
// directed transactions, hand-written reset/back-to-back sequences and random traffic.
module tb_mem_fill_ctrl;

   localparam int ENTRIES = 256;
   localparam int TIMEOUT = 16;
   localparam int MAXOFF  = 45;

   typedef struct {
      bit           wb;
      bit           fill;
      logic [26:0]  wa;
      logic [26:0]  fa;
      logic [255:0] wd;
      int           lat_w;
      int           lat_r;
      int           e_wr;
      int           e_wd;
      int           e_rd;
      int           e_rs;
      int           e_er;
      int           e_id;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_fill, req_wb;
   logic [26:0]  req_fill_addr, req_wb_addr;
   logic [255:0] req_wb_data;
   logic         resp_valid, wb_done, err;
   logic [255:0] resp_data;
   logic [26:0]  mem_a;
   logic [31:0]  mem_be;
   logic [255:0] mem_wd, mem_rd;
   logic         mem_write, mem_read, mem_valid, mem_ready;

   int vectors = 0;
   int miscompares = 0;

   logic [255:0] mem_lines [ENTRIES];
   logic [255:0] ref_mem   [ENTRIES];
   int wr_cnt, rd_cnt, rd_line, lat_w, lat_r;
   bit noise;

   mem_fill_ctrl #(.ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fill(req_fill), .req_wb(req_wb),
      .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
      .req_wb_data(req_wb_data),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .wb_done(wb_done), .err(err),
      .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic logic [255:0] rnd_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected event offsets (cycles after acceptance) from latency arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit   bad;
      int   t;
      r = v;
      r.e_wr = -1; r.e_wd = -1; r.e_rd = -1; r.e_rs = -1; r.e_er = -1; r.e_id = -1;
      bad = (v.wb && int'(v.wa) >= ENTRIES) || (v.fill && int'(v.fa) >= ENTRIES);
      if (bad) begin
         r.e_er = 1;
         return r;
      end
      if (!v.wb && !v.fill) begin
         r.e_id = 1;
         return r;
      end
      t = 1;
      if (v.wb) begin
         r.e_wr = 1;
         if (v.lat_w < 0 || v.lat_w >= TIMEOUT) begin
            r.e_er = 2 + TIMEOUT;
            return r;
         end
         r.e_wd = 3 + v.lat_w;
         t = 3 + v.lat_w;
         if (!v.fill) begin
            r.e_id = t;
            return r;
         end
      end
      r.e_rd = t;
      if (v.lat_r < 0 || v.lat_r >= TIMEOUT) begin
         r.e_er = t + 1 + TIMEOUT;
         return r;
      end
      r.e_rs = t + 2 + v.lat_r;
      r.e_id = r.e_rs + 1;
      return r;
   endfunction

   function automatic vec_t mk(input bit wb, input bit fill, input int wa, input int fa,
                               input logic [255:0] wd, input int lw, input int lr,
                               input int e_wr, input int e_wd, input int e_rd,
                               input int e_rs, input int e_er, input int e_id);
      vec_t v;
      v.wb = wb; v.fill = fill; v.wa = 27'(wa); v.fa = 27'(fa); v.wd = wd;
      v.lat_w = lw; v.lat_r = lr;
      v.e_wr = e_wr; v.e_wd = e_wd; v.e_rd = e_rd; v.e_rs = e_rs; v.e_er = e_er; v.e_id = e_id;
      return v;
   endfunction

   // One clock: memory responds to pulses seen in the previous cycle.
   task automatic step();
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_valid = 1'b0;
      mem_rd    = rnd_line();
      if (wr_cnt > 0) begin
         wr_cnt--;
         if (wr_cnt == 0) mem_ready = 1'b1;
      end
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            mem_valid = 1'b1;
            if (rd_line < ENTRIES) mem_rd = mem_lines[rd_line];
         end
      end
      if (noise) begin
         if (rd_cnt > 0 && $urandom_range(0, 1) == 1) mem_ready = 1'b1;
         if (wr_cnt > 0 && $urandom_range(0, 1) == 1) mem_valid = 1'b1;
      end
      if (mem_write) begin
         if (int'(mem_a) < ENTRIES) mem_lines[mem_a] = mem_wd;
         if (lat_w >= 0) wr_cnt = lat_w + 1;
      end
      if (mem_read) begin
         rd_line = int'(mem_a);
         if (lat_r >= 0) rd_cnt = lat_r + 1;
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      req_valid = 1'b0;
      step();
      rst = 1'b0;
      wr_cnt = 0;
      rd_cnt = 0;
      mem_valid = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int wr_off, rd_off, wd_off, rs_off, er_off, id_off;
      int n_wr, n_rd, n_wd, n_rs, viol;
      bit prev_rd, prev_wr, bad;
      logic [255:0] exp_data;
      bad = (v.wb && int'(v.wa) >= ENTRIES) || (v.fill && int'(v.fa) >= ENTRIES);
      if (v.wb && !bad) ref_mem[v.wa] = v.wd;
      exp_data = (v.fill && int'(v.fa) < ENTRIES) ? ref_mem[v.fa] : '0;
      lat_w = v.lat_w;
      lat_r = v.lat_r;
      wr_off = -1; rd_off = -1; wd_off = -1; rs_off = -1; er_off = -1; id_off = -1;
      n_wr = 0; n_rd = 0; n_wd = 0; n_rs = 0; viol = 0;
      prev_rd = 1'b0; prev_wr = 1'b0;
      check_int({tag, ".ready_at_accept"}, int'(req_ready), 1);
      if (!req_ready) reset_dut();
      req_valid = 1'b1;
      req_wb = v.wb;
      req_fill = v.fill;
      req_wb_addr = v.wa;
      req_fill_addr = v.fa;
      req_wb_data = v.wd;
      for (int off = 1; off <= MAXOFF; off++) begin
         step();
         if (off == 1) begin
            req_valid = 1'b0;
            req_wb = 1'($urandom);
            req_fill = 1'($urandom);
            req_wb_addr = 27'($urandom);
            req_fill_addr = 27'($urandom);
            req_wb_data = rnd_line();
         end
         if (mem_write) begin
            n_wr++;
            if (wr_off < 0) begin
               wr_off = off;
               check({tag, ".wr_addr"}, 256'(mem_a), 256'(v.wa));
               check({tag, ".wr_data"}, mem_wd, v.wd);
               check({tag, ".wr_be"}, 256'(mem_be), 256'(32'hFFFF_FFFF));
            end
         end
         if (mem_read) begin
            n_rd++;
            if (rd_off < 0) begin
               rd_off = off;
               check({tag, ".rd_addr"}, 256'(mem_a), 256'(v.fa));
            end
         end
         if (wb_done) begin
            n_wd++;
            if (wd_off < 0) wd_off = off;
         end
         if (resp_valid) begin
            n_rs++;
            if (rs_off < 0) begin
               rs_off = off;
               check({tag, ".resp_data"}, resp_data, exp_data);
            end
         end
         if (err) begin
            if (er_off < 0) er_off = off;
            if (mem_read || mem_write || req_ready) viol++;
         end else if (er_off >= 0) begin
            viol++;
         end
         if (req_ready && id_off < 0) id_off = off;
         if (mem_read && mem_write) viol++;
         if ((mem_read && prev_rd) || (mem_write && prev_wr)) viol++;
         if (!mem_read && !mem_write && (mem_a != '0 || mem_be != '0)) viol++;
         prev_rd = mem_read;
         prev_wr = mem_write;
      end
      check_int({tag, ".wr_off"}, wr_off, v.e_wr);
      check_int({tag, ".rd_off"}, rd_off, v.e_rd);
      check_int({tag, ".wb_done_off"}, wd_off, v.e_wd);
      check_int({tag, ".resp_off"}, rs_off, v.e_rs);
      check_int({tag, ".err_off"}, er_off, v.e_er);
      check_int({tag, ".idle_off"}, id_off, v.e_id);
      check_int({tag, ".n_write"}, n_wr, (v.e_wr >= 0) ? 1 : 0);
      check_int({tag, ".n_read"}, n_rd, (v.e_rd >= 0) ? 1 : 0);
      check_int({tag, ".n_wb_done"}, n_wd, (v.e_wd >= 0) ? 1 : 0);
      check_int({tag, ".n_resp"}, n_rs, (v.e_rs >= 0) ? 1 : 0);
      check_int({tag, ".protocol"}, viol, 0);
      if (v.e_rs >= 0) check({tag, ".resp_hold"}, resp_data, exp_data);
      if (v.e_er >= 0 || er_off >= 0) begin
         reset_dut();
         check_int({tag, ".err_cleared"}, int'(err), 0);
         check_int({tag, ".ready_after_rst"}, int'(req_ready), 1);
      end
   endtask

   vec_t tbl [13];
   vec_t rv;

   initial begin
      int n_req, n_rd, n_rs, rdc0, rdc1, viol;
      bit prev_rd;
      logic [255:0] a5, w1234;
      logic [255:0] exp_resp [2];

      rst = 1'b0; req_valid = 1'b0; req_fill = 1'b0; req_wb = 1'b0;
      req_fill_addr = '0; req_wb_addr = '0; req_wb_data = '0;
      mem_rd = '0; mem_valid = 1'b0; mem_ready = 1'b0;
      wr_cnt = 0; rd_cnt = 0; rd_line = 0; lat_w = 2; lat_r = 2; noise = 1'b0;
      a5 = {32{8'hA5}};
      w1234 = {8{32'h1234_5678}};
      for (int i = 0; i < ENTRIES; i++) begin
         mem_lines[i] = rnd_line();
         ref_mem[i] = mem_lines[i];
      end
      mem_lines[5] = a5;
      ref_mem[5] = a5;

      reset_dut();
      check_int("reset.req_ready", int'(req_ready), 1);
      check_int("reset.strobes", int'({resp_valid, wb_done, err, mem_read, mem_write}), 0);
      check("reset.mem_a_be", 256'({mem_a, mem_be}), '0);
      check("reset.mem_wd", mem_wd, '0);
      check("reset.resp_data", resp_data, '0);

      tbl[0]  = mk(0, 1,   0,   5, '0,     2,  2, -1, -1,  1,  5, -1,  6);
      tbl[1]  = mk(1, 1,   3,   3, w1234,  2,  2,  1,  5,  5,  9, -1, 10);
      tbl[2]  = mk(0, 1,   0, 256, '0,     2,  2, -1, -1, -1, -1,  1, -1);
      tbl[3]  = mk(0, 1,   0,   7, '0,     2, -1, -1, -1,  1, -1, 18, -1);
      tbl[4]  = mk(0, 1,   0,   6, '0,     2, 16, -1, -1,  1, -1, 18, -1);
      tbl[5]  = mk(0, 1,   0,   9, '0,     2, 15, -1, -1,  1, 18, -1, 19);
      tbl[6]  = mk(1, 0,  10,   0, rnd_line(), 0, 2, 1,  3, -1, -1, -1,  3);
      tbl[7]  = mk(0, 0, 300, 400, '0,     2,  2, -1, -1, -1, -1, -1,  1);
      tbl[8]  = mk(1, 1, 255, 255, rnd_line(), 15, 15, 1, 18, 18, 35, -1, 36);
      tbl[9]  = mk(1, 1, 256,   0, rnd_line(), 2, 2, -1, -1, -1, -1,  1, -1);
      tbl[10] = mk(0, 1, 300,   9, '0,     2,  0, -1, -1,  1,  3, -1,  4);
      tbl[11] = mk(1, 1,   4,   4, rnd_line(), -1, 2, 1, -1, -1, -1, 18, -1);
      tbl[12] = mk(1, 1,  20,  21, rnd_line(), 0, 0, 1,  3,  3,  5, -1,  6);

      for (int i = 0; i < 13; i++) begin
         run_txn(tbl[i], $sformatf("tbl%0d", i));
         if (i == 0) check("tbl0.resp_a5", resp_data, a5);
         if (i == 1) check("tbl1.resp_1234", resp_data, w1234);
      end

      // Reset while waiting for read data; the late mem_valid must be ignored.
      lat_w = 2; lat_r = 2;
      req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1; req_fill_addr = 27'd8;
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_int("midrst.req_ready", int'(req_ready), 1);
      check("midrst.resp_data", resp_data, '0);
      viol = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (resp_valid || wb_done || err || mem_read || mem_write) viol++;
      end
      check_int("midrst.no_strobes", viol, 0);

      // Back-to-back fills at lines 1 and 2, second request as soon as ready.
      lat_r = 0;
      exp_resp[0] = ref_mem[1];
      exp_resp[1] = ref_mem[2];
      n_req = 0; n_rd = 0; n_rs = 0; rdc0 = -1; rdc1 = -1; viol = 0; prev_rd = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         req_valid = 1'b0;
         if (n_req < 2 && req_ready) begin
            req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1;
            req_fill_addr = (n_req == 0) ? 27'd1 : 27'd2;
            n_req++;
         end
         if (mem_read) begin
            if (prev_rd) viol++;
            if (n_rd == 0) rdc0 = c; else rdc1 = c;
            check($sformatf("b2b.rd_addr%0d", n_rd), 256'(mem_a), 256'(n_rd + 1));
            n_rd++;
         end
         prev_rd = mem_read;
         if (resp_valid) begin
            if (n_rs < 2) check($sformatf("b2b.resp%0d", n_rs), resp_data, exp_resp[n_rs]);
            n_rs++;
         end
      end
      req_valid = 1'b0;
      check_int("b2b.n_read", n_rd, 2);
      check_int("b2b.n_resp", n_rs, 2);
      check_int("b2b.rd_cycle0", rdc0, 1);
      check_int("b2b.rd_cycle1", rdc1, 5);
      check_int("b2b.adjacent", viol, 0);

      noise = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rv.wb   = 1'($urandom);
         rv.fill = ($urandom_range(0, 3) != 0);
         rv.wa   = ($urandom_range(0, 15) == 0) ? 27'(ENTRIES + int'($urandom_range(0, 1000)))
                                                : 27'($urandom_range(0, ENTRIES - 1));
         rv.fa   = ($urandom_range(0, 15) == 0) ? 27'(ENTRIES + int'($urandom_range(0, 1000)))
                                                : 27'($urandom_range(0, ENTRIES - 1));
         rv.wd   = rnd_line();
         rv.lat_w = ($urandom_range(0, 9) == 0) ? -1 :
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
         rv.lat_r = ($urandom_range(0, 9) == 0) ? -1 :
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
         rv = model(rv);
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 256: number of 256-bit main-memory lines; legal line addresses are 0..ENTRIES-1.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for mem_ready or mem_valid.
REQ-003 SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  cache request present.
- req_ready  out  1  controller can accept a request.
- req_fill  in  1  read the line at req_fill_addr.
- req_wb  in  1  write back the dirty line first.
- req_fill_addr  in  27  fill line address.
- req_wb_addr  in  27  writeback line address.
- req_wb_data  in  256  writeback data.
- resp_valid  out  1  one-cycle fill-data strobe.
- resp_data  out  256  fill data.
- wb_done  out  1  one-cycle writeback-complete strobe.
- err  out  1  sticky error flag.
- mem_a  out  27  memory line address.
- mem_be  out  32  memory byte enables.
- mem_wd  out  256  memory write data.
- mem_write  out  1  memory write pulse.
- mem_read  out  1  memory read pulse.
- mem_rd  in  256  memory read data.
- mem_valid  in  1  read data valid.
- mem_ready  in  1  write complete.

Function
REQ-004 SHALL implement the states IDLE, WB_ISSUE, WB_WAIT, RD_ISSUE, RD_WAIT, RESP and ERROR; req_ready SHALL be 1 only in IDLE.
REQ-005 SHALL accept a request in IDLE on req_valid&req_ready and register both addresses, req_wb_data and both flags in that cycle.
- Input changes after acceptance SHALL have no effect.
REQ-006 SHALL check range on acceptance.
- If any enabled address (wb if req_wb, fill if req_fill) is >= ENTRIES: go to ERROR, issue no memory access.
REQ-007 SHALL go from acceptance to the next state as follows:
- req_wb=1: WB_ISSUE.
- req_wb=0, req_fill=1: RD_ISSUE.
- Neither flag set: stay in IDLE (no-op).
REQ-008 SHALL, in WB_ISSUE, drive for exactly one cycle: mem_write=1, mem_a=wb address, mem_wd=wb data, mem_be=32'hFFFFFFFF; then go to WB_WAIT.
REQ-009 SHALL, in WB_WAIT on mem_ready=1, pulse wb_done for one cycle (next cycle), then go to RD_ISSUE if the fill flag is set, else to IDLE.
REQ-010 SHALL, in RD_ISSUE, drive mem_read=1 and mem_a=fill address for exactly one cycle; then go to RD_WAIT.
REQ-011 SHALL, in RD_WAIT on mem_valid=1, capture mem_rd into resp_data and go to RESP.
REQ-012 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE.
REQ-013 SHALL hold resp_data stable until the next capture.
REQ-014 SHALL never assert mem_read and mem_write together, and SHALL never assert either for two consecutive cycles; the memory drops back-to-back pulses.
REQ-015 SHALL drive mem_write, mem_read, mem_be and mem_a to 0 outside the ISSUE states.
REQ-016 SHALL count wait cycles in WB_WAIT and RD_WAIT with a counter cleared on entry.
- If the counter reaches TIMEOUT without the awaited strobe: go to ERROR.
REQ-017 SHALL ignore mem_valid and mem_ready outside the state that awaits them.
REQ-018 SHALL hold err=1 in ERROR, keep req_ready=0 and issue no memory access until rst.
REQ-019 SHALL yield nominal latency, acceptance to resp_valid, of 5 cycles for a fill only and 9 cycles for writeback+fill, with a 2-cycle memory.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, enter IDLE, clear the counter and set to 0: req_ready→1 after reset, resp_valid, wb_done, err, mem_read, mem_write, mem_a, mem_be, mem_wd, resp_data.
REQ-021 SHALL make reset mid-transaction abandon that transaction with no further strobes; a late mem_valid or mem_ready SHALL be ignored.

Verification
REQ-022 SHALL cover a fill only: fill_addr=5, memory line 5=0xA5..A5 -> one mem_read pulse with mem_a=5; resp_data=0xA5..A5 with resp_valid 5 cycles after acceptance.
REQ-023 SHALL cover writeback+fill: wb_addr=3 with data 0x1234..., fill_addr=3 -> mem_write pulse, wb_done, mem_read pulse; resp_data=0x1234...
REQ-024 SHALL cover out of range: fill_addr=256 -> err=1, req_ready=0, no mem_read; rst clears err.
REQ-025 SHALL cover timeout: mem_valid held 0 -> err=1 after 16 RD_WAIT cycles.
REQ-026 SHALL cover reset during RD_WAIT followed by a mem_valid pulse -> no resp_valid; req_ready=1 the cycle after reset.
REQ-027 SHALL cover back-to-back fills at addresses 1 and 2 -> two single-cycle mem_read pulses, never adjacent, with correct resp_data each.
